// File: rtl/io_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// io_bus_arbiter_if
// Bundle of the two master request ports (m0 = CPU data, m1 = debug/loader)
// and the shared IO slave port.
//   slave  : arbiter view. Takes master requests, returns ack/rdata,
//            drives the IO strobes and samples io_rdata.
//   master : environment view. Drives requests and io_rdata, observes the rest.
// ---------------------------------------------------------------------------
interface io_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req, m0_we, m0_lock, m0_ack;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_lock, m1_ack;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic              io_ce, io_we;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata, io_rdata;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output io_ce, io_we, io_addr, io_wdata,
    input  io_rdata
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  io_ce, io_we, io_addr, io_wdata,
    output io_rdata
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// ---------------------------------------------------------------------------
// io_bus_arbiter
// Shares one memory-mapped IO slave between two masters with round-robin
// arbitration and an optional bus lock for read-modify-write sequences.
// Every access runs IDLE -> ACCESS -> RESP (one access per 3 cycles).
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : io_bus_arbiter_if.slave (m0_*/m1_* request ports, io_* slave port)
// All outputs are registered.
// ---------------------------------------------------------------------------
module io_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LOCK_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  io_bus_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t                  state_q;
  logic                    gnt_q;       // master owning the current access
  logic                    last_q;      // last granted master (round-robin)
  logic                    lat_we_q;
  logic                    lat_lock_q;
  logic                    lock_vld_q;
  logic                    lock_own_q;
  logic [CNT_W-1:0]        lock_cnt_q;
  logic [1:0]              ack_q;
  logic [1:0][DATA_W-1:0]  rdata_q;
  logic                    io_ce_q, io_we_q;
  logic [ADDR_W-1:0]       io_addr_q;
  logic [DATA_W-1:0]       io_wdata_q;

  req_t [1:0]              mreq;
  logic [1:0]              req, elig;
  logic                    gnt_vld_d, gnt_id_d;

  always_comb begin
    mreq[0] = '{we: bus.m0_we, lock: bus.m0_lock, addr: bus.m0_addr, wdata: bus.m0_wdata};
    mreq[1] = '{we: bus.m1_we, lock: bus.m1_lock, addr: bus.m1_addr, wdata: bus.m1_wdata};
    req     = {bus.m1_req, bus.m0_req};
    // A held lock masks the non-owner entirely.
    elig    = req;
    if (lock_vld_q) elig = lock_own_q ? {req[1], 1'b0} : {1'b0, req[0]};
    gnt_vld_d = |elig;
    // Under lock at most one bit of elig is set, so last_q is ignored there.
    gnt_id_d  = (&elig) ? ~last_q : elig[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;       // m0 wins the first contention
      lat_we_q   <= 1'b0;
      lat_lock_q <= 1'b0;
      lock_vld_q <= 1'b0;
      lock_own_q <= 1'b0;
      lock_cnt_q <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      io_ce_q    <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= '0;
      io_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            gnt_q      <= gnt_id_d;
            last_q     <= gnt_id_d;
            lat_we_q   <= mreq[gnt_id_d].we;
            lat_lock_q <= mreq[gnt_id_d].lock;
            io_ce_q    <= 1'b1;
            io_we_q    <= mreq[gnt_id_d].we;
            io_addr_q  <= mreq[gnt_id_d].addr;
            io_wdata_q <= mreq[gnt_id_d].wdata;
            state_q    <= ACCESS;
          end else if (lock_vld_q) begin
            // Owner idle: count down; the release is seen by the next IDLE.
            lock_cnt_q <= lock_cnt_q - CNT_W'(1);
            if (lock_cnt_q == CNT_W'(1)) lock_vld_q <= 1'b0;
          end
        end
        ACCESS: begin
          io_ce_q        <= 1'b0;
          io_we_q        <= 1'b0;
          io_addr_q      <= '0;
          io_wdata_q     <= '0;
          ack_q[gnt_q]   <= 1'b1;
          rdata_q[gnt_q] <= lat_we_q ? '0 : bus.io_rdata;
          state_q        <= RESP;
        end
        RESP: begin
          ack_q      <= '0;
          rdata_q    <= '0;
          // Only the owner can be granted while locked, so the latched lock
          // bit alone decides whether the lock is (re)armed or released.
          lock_vld_q <= lat_lock_q;
          lock_own_q <= gnt_q;
          lock_cnt_q <= lat_lock_q ? CNT_W'(LOCK_TIMEOUT) : '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m0_ack   = ack_q[0];
  assign bus.m1_ack   = ack_q[1];
  assign bus.m0_rdata = rdata_q[0];
  assign bus.m1_rdata = rdata_q[1];
  assign bus.io_ce    = io_ce_q;
  assign bus.io_we    = io_we_q;
  assign bus.io_addr  = io_addr_q;
  assign bus.io_wdata = io_wdata_q;
endmodule

// File: tb/tb_io_bus_arbiter.sv
module tb_io_bus_arbiter;
  localparam logic [31:0] SEG = 32'h0000_0010;
  localparam logic [31:0] KEY = 32'h0000_0014;
  localparam logic [31:0] A0  = 32'h0000_0100;
  localparam logic [31:0] A1  = 32'h0000_0200;
  localparam logic [31:0] A2  = 32'h0000_0300;
  localparam int          TO  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   idle_cnt;

  always #5 clk = ~clk;

  io_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  io_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_lock = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_lock = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.io_rdata = 32'hDEAD_BEEF;

    // reset state
    tick(); tick();
    chk("rst_io_ce", {31'b0, bus.io_ce}, 0);
    chk("rst_io_addr", bus.io_addr, 0);
    chk("rst_acks", {30'b0, bus.m1_ack, bus.m0_ack}, 0);
    chk("rst_m0_rdata", bus.m0_rdata, 0);
    rst = 0;

    // single write from m0
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = SEG; bus.m0_wdata = 32'h0000_00FF;
    tick();                                       // ACCESS
    chk("wr_io_ce", {31'b0, bus.io_ce}, 1);
    chk("wr_io_we", {31'b0, bus.io_we}, 1);
    chk("wr_io_addr", bus.io_addr, SEG);
    chk("wr_io_wdata", bus.io_wdata, 32'h0000_00FF);
    chk("wr_ack_early", {31'b0, bus.m0_ack}, 0);
    tick();                                       // RESP
    chk("wr_io_ce_off", {31'b0, bus.io_ce}, 0);
    chk("wr_m0_ack", {31'b0, bus.m0_ack}, 1);
    chk("wr_m1_ack", {31'b0, bus.m1_ack}, 0);
    chk("wr_rdata_zero", bus.m0_rdata, 0);
    tick();                                       // IDLE
    bus.m0_req = 0; bus.m0_we = 0;
    chk("wr_ack_drop", {31'b0, bus.m0_ack}, 0);
    tick();
    chk("wr_no_regrant", {31'b0, bus.io_ce}, 0);

    // single read from m1
    bus.io_rdata = 32'h2;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = KEY;
    chk("rd_rdata_before", bus.m1_rdata, 0);
    tick();                                       // ACCESS
    chk("rd_io_ce", {31'b0, bus.io_ce}, 1);
    chk("rd_io_we", {31'b0, bus.io_we}, 0);
    chk("rd_io_addr", bus.io_addr, KEY);
    chk("rd_rdata_access", bus.m1_rdata, 0);
    tick();                                       // RESP
    chk("rd_m1_ack", {31'b0, bus.m1_ack}, 1);
    chk("rd_m1_rdata", bus.m1_rdata, 32'h2);
    chk("rd_m0_ack", {31'b0, bus.m0_ack}, 0);
    chk("rd_m0_rdata", bus.m0_rdata, 0);
    tick();                                       // IDLE
    bus.m1_req = 0;
    chk("rd_rdata_after", bus.m1_rdata, 0);

    // contention from reset: m0, m1, m0, m1
    rst = 1;
    bus.io_rdata = 32'h55;
    bus.m0_req = 1; bus.m0_addr = A0;
    bus.m1_req = 1; bus.m1_addr = A1;
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();                                     // ACCESS
      chk($sformatf("cont%0d_addr", i), bus.io_addr, (i % 2 == 0) ? A0 : A1);
      tick();                                     // RESP
      chk($sformatf("cont%0d_acks", i), {30'b0, bus.m1_ack, bus.m0_ack},
          (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();                                     // IDLE
      chk($sformatf("cont%0d_idle", i), {31'b0, bus.io_ce}, 0);
    end
    bus.m0_req = 0; bus.m1_req = 0;

    // lock held: m0 locks, re-requests after 3 idle cycles, m1 waits
    bus.m0_req = 1; bus.m0_lock = 1; bus.m0_addr = A0;
    bus.m1_req = 1; bus.m1_addr = A1;
    tick();
    chk("lk_addr0", bus.io_addr, A0);
    tick();
    chk("lk_ack0", {31'b0, bus.m0_ack}, 1);
    tick();                                       // idle 1
    bus.m0_req = 0; bus.m0_lock = 0;
    tick();
    chk("lk_blk2", {31'b0, bus.io_ce}, 0);
    tick();
    chk("lk_blk3", {31'b0, bus.io_ce}, 0);
    tick();
    chk("lk_blk4", {31'b0, bus.io_ce}, 0);
    bus.m0_req = 1; bus.m0_addr = A2;             // owner returns, lock=0
    tick();
    chk("lk_owner_again", bus.io_addr, A2);
    tick();
    chk("lk_acks1", {30'b0, bus.m1_ack, bus.m0_ack}, 1);
    tick();
    bus.m0_req = 0;
    tick();
    chk("lk_m1_after", bus.io_addr, A1);
    tick();
    chk("lk_m1_ack", {31'b0, bus.m1_ack}, 1);
    tick();
    bus.m1_req = 0;

    // lock timeout: m0 locks and disappears, m1 requests throughout
    bus.m0_req = 1; bus.m0_lock = 1; bus.m0_addr = A0;
    bus.m1_req = 1; bus.m1_addr = A1;
    tick();
    chk("to_addr0", bus.io_addr, A0);
    tick();
    chk("to_ack0", {31'b0, bus.m0_ack}, 1);
    tick();                                       // first idle cycle
    bus.m0_req = 0; bus.m0_lock = 0;
    idle_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.io_ce) break;
      idle_cnt++;
      tick();
    end
    // TO blocked idle cycles plus the idle cycle in which m1 is granted
    chk("to_idle_cycles", idle_cnt, TO + 1);
    chk("to_m1_addr", bus.io_addr, A1);
    tick();
    chk("to_m1_ack", {31'b0, bus.m1_ack}, 1);
    tick();
    bus.m1_req = 0;

    // reset during an m1 write ACCESS
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = SEG; bus.m1_wdata = 32'hAB;
    tick();
    chk("rs_io_ce_on", {31'b0, bus.io_ce}, 1);
    #1 rst = 1;
    #1;
    chk("rs_io_ce_async", {31'b0, bus.io_ce}, 0);
    bus.m1_we = 0; bus.m1_addr = A1;
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = A0;
    tick();
    chk("rs_no_ack", {30'b0, bus.m1_ack, bus.m0_ack}, 0);
    rst = 0;
    tick();
    chk("rs_m0_wins", bus.io_addr, A0);
    tick();
    chk("rs_m0_ack", {30'b0, bus.m1_ack, bus.m0_ack}, 1);
    tick();
    bus.m0_req = 0; bus.m1_req = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single memory-mapped IO slave port (ce/we/addr/wtData/rdData) between two bus masters: m0 (CPU data port) and m1 (debug/loader engine).
- Round-robin arbitration with an optional bus lock for read-modify-write sequences.
- Each access is registered and sequenced through a fixed 3-cycle IDLE→ACCESS→RESP handshake.
- Sits between the masters and the IO block; drives its ce/we.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LOCK_TIMEOUT, 8, idle cycles a lock is held waiting for the owner to re-request (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- m0_req  in  1  m0 request, level; held until m0_ack.
- m0_we  in  1  m0 write enable (1 = write).
- m0_lock  in  1  m0 requests bus retention after this access.
- m0_addr  in  ADDR_W  m0 address.
- m0_wdata  in  DATA_W  m0 write data.
- m0_ack  out  1  one-cycle completion pulse to m0.
- m0_rdata  out  DATA_W  read data, valid while m0_ack=1.
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0_* for m1.
- io_ce  out  1  IO chip enable.
- io_we  out  1  IO write enable.
- io_addr  out  ADDR_W  IO address.
- io_wdata  out  DATA_W  IO write data.
- io_rdata  in  DATA_W  IO combinational read data.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, all outputs 0.
  - last_grant=1, so m0 wins the first contention.
  - lock_owner=none, lock_cnt=0, latched addr/data/we=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Evaluate m0_req/m1_req.
  - Single requester: grant it.
  - Both requesting: grant the master ≠ last_grant.
  - On grant: latch addr/we/wdata/lock of the winner, set last_grant=winner, go ACCESS.
  - No request: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - io_ce=1, io_we=latched we, io_addr/io_wdata=latched values.
  - IO write commits at the closing edge.
  - For reads, io_rdata is captured into rdata_reg at the closing edge.
  - Go RESP.
- RESP (1 cycle):
  - Granted master's ack=1 and rdata=rdata_reg; the other master's ack=0 and rdata=0.
  - io_ce=0.
  - Go IDLE.
- Latency: request seen in IDLE at edge N → ACCESS in cycle N+1 → ack in cycle N+2. Sustained throughput is one access per 3 cycles.
- Master obligations:
  - Sample ack at the rising edge and deassert req (or present a new request) from that edge.
  - req must be low in the IDLE cycle that follows ack unless a new access is intended.
- Non-granted outputs: io_* hold 0 outside ACCESS; rdata outputs are 0 except during ack.
- rdata on writes: rdata_reg is loaded with 0.
- Lock:
  - If the latched lock=1 at RESP, lock_owner=granted master and lock_cnt=LOCK_TIMEOUT.
  - In IDLE with lock_owner set, only the owner's req is eligible.
  - Each IDLE cycle without an owner request decrements lock_cnt.
  - When lock_cnt reaches 0, the lock clears and arbitration resumes the same cycle the counter hits 0, evaluated the following IDLE cycle.
  - An owner access with lock=0 clears the lock at its RESP.
  - While locked, last_grant is not used; after release, normal round-robin applies.
- Simultaneous events:
  - A req rising during ACCESS/RESP is only evaluated in the next IDLE.
  - Both masters granted in the same cycle is impossible.
- Reset mid-operation:
  - The access is aborted and no ack is issued; io_ce drops asynchronously.
  - A write in ACCESS may or may not have committed; the master must reissue.
- Widths: addr/data pass through unmodified. There is no decode; the IO slave decodes addresses.

Test Plan:
- Single write: m0 writes 32'h0000_00FF to `SEG, m1 idle → io_ce=io_we=1 for exactly 1 cycle with the address/data, m0_ack 2 cycles after grant, m1_ack stays 0.
- Single read: m1 reads `KEY with io_rdata=32'h2 → m1_ack pulse with m1_rdata=32'h2; m1_rdata=0 in cycles before and after.
- Contention:
  - Both masters request continuously from reset (distinct addresses) → grant order m0, m1, m0, m1.
  - Each access takes 3 cycles; io_addr alternates accordingly.
- Lock held:
  - m0 accesses with lock=1, then re-requests 3 idle cycles later while m1 requests throughout → m0 granted again.
  - m1 is granted only after m0 issues a lock=0 access.
- Lock timeout: m0 accesses with lock=1 then never re-requests; m1 requests throughout → m1 is granted after exactly LOCK_TIMEOUT=8 blocked IDLE cycles.
- Reset in ACCESS: assert rst during an m1 write's ACCESS cycle → io_ce=0 immediately, no m1_ack, state IDLE, and the next contention is won by m0.
